// File: rtl/rcc_reg_pkg.sv
// Shared definitions for the RCC register-bus target: FSM encoding, ID default,
// register index constants and the privileged-region boundary.
package rcc_reg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_e;

    localparam logic [63:0] ID_VAL_DEF = 64'h0000_0000_5243_4301;

    localparam int unsigned REG_IDX_ID = 0;
    localparam int unsigned CNT_W      = 4;
    localparam int unsigned ERRCNT_W   = 16;

    function automatic int unsigned errcnt_idx(input int unsigned nreg);
        return nreg - 1;
    endfunction

    // Upper half of the bank is writable only by the privileged master.
    function automatic logic is_protected(input int unsigned idx, input int unsigned nreg);
        return idx >= (nreg / 2);
    endfunction

endpackage

// File: rtl/rcc_reg_tgt_if.sv
// Request/response bus between the RCC AHB-to-register bridge and its register target.
interface rcc_reg_tgt_if #(
    parameter int DW = 64,
    parameter int AW = 15
);
    localparam int WW = DW / 8;

    logic          mreq;
    logic          mwrite;
    logic [AW-1:0] maddr;
    logic [WW-1:0] mwstrb;
    logic [DW-1:0] mdata;
    logic          mmaster;
    logic [DW-1:0] sdata;
    logic          sready;
    logic          sresp;

    modport master (
        output mreq, mwrite, maddr, mwstrb, mdata, mmaster,
        input  sdata, sready, sresp
    );

    modport slave (
        input  mreq, mwrite, maddr, mwstrb, mdata, mmaster,
        output sdata, sready, sresp
    );

endinterface

// File: rtl/rcc_reg_tgt_bank.sv
// RCC control/status register array: byte-strobed writes, read mux, flat export.
// With RCC_REG_TGT_ERRCNT_EN the last register is a saturating error counter.
module rcc_reg_tgt_bank
    import rcc_reg_pkg::*;
#(
    parameter int          DW     = 64,
    parameter int unsigned NREG   = 16,
    parameter logic [DW-1:0] ID_VAL = ID_VAL_DEF
) (
    input  logic                    hclk,
    input  logic                    hresetn,
    input  logic                    we,
    input  logic [$clog2(NREG)-1:0] idx,
    input  logic [DW/8-1:0]         wstrb,
    input  logic [DW-1:0]           wdata,
`ifdef RCC_REG_TGT_ERRCNT_EN
    input  logic                    err_inc,
`endif
    output logic [DW-1:0]           rdata,
    output logic [NREG*DW-1:0]      reg_q
);

    localparam int IW = $clog2(NREG);
    localparam int WW = DW / 8;

    for (genvar g = 0; g < NREG; g++) begin : g_reg
        if (g == REG_IDX_ID) begin : g_id
            assign reg_q[g*DW +: DW] = ID_VAL;
        end
`ifdef RCC_REG_TGT_ERRCNT_EN
        else if (g == errcnt_idx(NREG)) begin : g_errcnt
            logic [ERRCNT_W-1:0] cnt_q;

            always_ff @(posedge hclk or negedge hresetn) begin
                if (!hresetn) begin
                    cnt_q <= '0;
                end else if (err_inc && (cnt_q != {ERRCNT_W{1'b1}})) begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end

            assign reg_q[g*DW +: DW] = {{(DW-ERRCNT_W){1'b0}}, cnt_q};
        end
`endif
        else begin : g_rw
            logic [DW-1:0] r_q;

            always_ff @(posedge hclk or negedge hresetn) begin
                if (!hresetn) begin
                    r_q <= '0;
                end else if (we && (idx == IW'(g))) begin
                    for (int b = 0; b < WW; b++) begin
                        if (wstrb[b]) begin
                            r_q[b*8 +: 8] <= wdata[b*8 +: 8];
                        end
                    end
                end
            end

            assign reg_q[g*DW +: DW] = r_q;
        end
    end

    always_comb begin
        rdata = reg_q[idx*DW +: DW];
    end

endmodule

// File: rtl/rcc_reg_tgt.sv
// RCC register-bus target: wait-state FSM, error decode and response registers
// around the register bank. Optional feature macro: RCC_REG_TGT_ERRCNT_EN.
//
// state   | meaning
// ST_IDLE | no transfer in flight, waiting for mreq
// ST_WAIT | wait-state countdown, request held stable by the initiator
// ST_ACK  | sready pulse; sdata/sresp valid, any write already committed
module rcc_reg_tgt
    import rcc_reg_pkg::*;
#(
    parameter int            DW     = 64,
    parameter int            AW     = 15,
    parameter int unsigned   NREG   = 16,
    parameter int unsigned   WAIT   = 1,
    parameter logic [DW-1:0] ID_VAL = ID_VAL_DEF
) (
    input  logic               hclk,
    input  logic               hresetn,
    rcc_reg_tgt_if.slave       bus,
    output logic [NREG*DW-1:0] reg_q
);

    localparam int IW = $clog2(NREG);
    localparam logic [CNT_W-1:0] WAIT_LD = (WAIT > 0) ? CNT_W'(WAIT - 1) : '0;

    state_e           state_q;
    state_e           state_nxt;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_nxt;

    logic [IW-1:0]    idx;
    logic             addr_oob;
    logic             wr_denied;
    logic             err;
    logic             enter_ack;
    logic             bank_we;
    logic [DW-1:0]    rdata;
    logic [DW-1:0]    sdata_q;
    logic             sresp_q;

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
        end
    end

    // ACK reuses the IDLE rule so a held mreq starts the next transfer at once.
    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        case (state_q)
            ST_IDLE, ST_ACK: begin
                if (bus.mreq) begin
                    if (WAIT > 0) begin
                        state_nxt = ST_WAIT;
                        cnt_nxt   = WAIT_LD;
                    end else begin
                        state_nxt = ST_ACK;
                    end
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_nxt = ST_ACK;
                end else begin
                    cnt_nxt = cnt_q - 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        idx       = bus.maddr[IW-1:0];
        addr_oob  = bus.maddr >= AW'(NREG);
        wr_denied = (idx == IW'(REG_IDX_ID))
                 || (bus.mmaster && is_protected(32'(idx), NREG));
`ifdef RCC_REG_TGT_ERRCNT_EN
        wr_denied = wr_denied || (idx == IW'(errcnt_idx(NREG)));
`endif
        err       = addr_oob || (bus.mwrite && wr_denied);
        enter_ack = (state_nxt == ST_ACK);
        bank_we   = enter_ack && bus.mwrite && !err;
    end

    // Response data is captured on the edge entering ACK and held afterwards.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            sdata_q <= '0;
            sresp_q <= 1'b0;
        end else begin
            sresp_q <= enter_ack && err;
            if (enter_ack) begin
                sdata_q <= err ? '0 : rdata;
            end
        end
    end

    assign bus.sready = (state_q == ST_ACK);
    assign bus.sresp  = sresp_q;
    assign bus.sdata  = sdata_q;

    rcc_reg_tgt_bank #(
        .DW     (DW),
        .NREG   (NREG),
        .ID_VAL (ID_VAL)
    ) u_bank (
        .hclk    (hclk),
        .hresetn (hresetn),
        .we      (bank_we),
        .idx     (idx),
        .wstrb   (bus.mwstrb),
        .wdata   (bus.mdata),
`ifdef RCC_REG_TGT_ERRCNT_EN
        .err_inc (enter_ack && err),
`endif
        .rdata   (rdata),
        .reg_q   (reg_q)
    );

endmodule

// File: tb/tb_rcc_reg_tgt.sv
// Self-checking bench for rcc_reg_tgt: directed vector table, hand sequences for
// back-to-back and mid-wait reset, then random transfers against a register model.
module tb_rcc_reg_tgt;

    localparam int          DW   = 64;
    localparam int          AW   = 15;
    localparam int          NREG = 16;
    localparam int          WAIT = 1;
    localparam logic [63:0] ID   = 64'h0000_0000_5243_4301;
`ifdef RCC_REG_TGT_ERRCNT_EN
    localparam bit ERRCNT = 1'b1;
`else
    localparam bit ERRCNT = 1'b0;
`endif

    logic               hclk = 1'b0;
    logic               hresetn;
    logic               rst3_n;
    logic [NREG*DW-1:0] reg_q;
    logic [NREG*DW-1:0] reg_q3;

    rcc_reg_tgt_if #(.DW(DW), .AW(AW)) bus  ();
    rcc_reg_tgt_if #(.DW(DW), .AW(AW)) bus3 ();

    rcc_reg_tgt #(.DW(DW), .AW(AW), .NREG(NREG), .WAIT(WAIT), .ID_VAL(ID)) dut (
        .hclk(hclk), .hresetn(hresetn), .bus(bus), .reg_q(reg_q)
    );

    rcc_reg_tgt #(.DW(DW), .AW(AW), .NREG(NREG), .WAIT(3), .ID_VAL(ID)) dut3 (
        .hclk(hclk), .hresetn(rst3_n), .bus(bus3), .reg_q(reg_q3)
    );

    always #5 hclk = ~hclk;

    int checks = 0;
    int errors = 0;

    logic [63:0] mregs [NREG];
    int unsigned merrcnt;

    typedef struct {
        logic        w;
        int          a;
        logic [7:0]  s;
        logic [63:0] d;
        logic        m;
        logic        exp_resp;
        logic        chk_data;
        logic [63:0] exp_data;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model_read(input int a);
        if (a == 0) return ID;
        if (ERRCNT && a == NREG - 1) return 64'(merrcnt);
        return mregs[a];
    endfunction

    task automatic model_apply(input logic w, input int a, input logic [7:0] s,
                               input logic [63:0] d, input logic m,
                               output logic exp_resp, output logic [63:0] exp_data);
        exp_resp = (a >= NREG)
                || (w && (a == 0 || (m && a >= NREG / 2) || (ERRCNT && a == NREG - 1)));
        if (exp_resp) begin
            exp_data = '0;
            if (ERRCNT && merrcnt < 32'hFFFF) merrcnt++;
        end else begin
            exp_data = model_read(a);
            if (w) begin
                for (int b = 0; b < 8; b++)
                    if (s[b]) mregs[a][8*b +: 8] = d[8*b +: 8];
            end
        end
    endtask

    task automatic chk_regs(input string tag);
        for (int i = 0; i < NREG; i++)
            chk($sformatf("%s reg_q[%0d]", tag, i), reg_q[i*DW +: DW], model_read(i));
    endtask

    // Caller is 1 time unit after a rising edge; returns edges until sready.
    task automatic xfer(input logic w, input int a, input logic [7:0] s,
                        input logic [63:0] d, input logic m,
                        output logic [63:0] rd, output logic rs, output int lat);
        bus.mwrite  = w;
        bus.maddr   = AW'(a);
        bus.mwstrb  = s;
        bus.mdata   = d;
        bus.mmaster = m;
        bus.mreq    = 1'b1;
        lat = 0;
        do begin
            @(posedge hclk); #1;
            lat++;
        end while (!bus.sready && lat < 20);
        rd = bus.sdata;
        rs = bus.sresp;
        bus.mreq = 1'b0;
    endtask

    initial begin
        logic [63:0] rd, ed, xv;
        logic        rs, er;
        int          lat, lat2;
        logic        w, m;
        int          a;
        logic [7:0]  s;
        logic [63:0] d;

        vecs[0]  = '{1'b0, 0,  8'h00, 64'h0,                  1'b0, 1'b0, 1'b1, ID};
        vecs[1]  = '{1'b1, 3,  8'h0F, 64'hAAAA_BBBB_CCCC_DDDD, 1'b0, 1'b0, 1'b0, 64'h0};
        vecs[2]  = '{1'b0, 3,  8'h00, 64'h0,                  1'b0, 1'b0, 1'b1, 64'h0000_0000_CCCC_DDDD};
        vecs[3]  = '{1'b0, 16, 8'h00, 64'h0,                  1'b0, 1'b1, 1'b1, 64'h0};
        vecs[4]  = '{1'b1, 16, 8'hFF, 64'h1111_2222_3333_4444, 1'b0, 1'b1, 1'b1, 64'h0};
        vecs[5]  = '{1'b1, 0,  8'hFF, 64'hDEAD_BEEF_DEAD_BEEF, 1'b0, 1'b1, 1'b1, 64'h0};
        vecs[6]  = '{1'b1, 9,  8'hFF, 64'h1234_5678_9ABC_DEF0, 1'b1, 1'b1, 1'b1, 64'h0};
        vecs[7]  = '{1'b0, 9,  8'h00, 64'h0,                  1'b1, 1'b0, 1'b1, 64'h0};
        vecs[8]  = '{1'b1, 9,  8'hFF, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0, 1'b0, 64'h0};
        vecs[9]  = '{1'b0, 9,  8'h00, 64'h0,                  1'b1, 1'b0, 1'b1, 64'h0123_4567_89AB_CDEF};
        vecs[10] = '{1'b1, 3,  8'h00, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 64'h0};
        vecs[11] = '{1'b0, 3,  8'h00, 64'h0,                  1'b0, 1'b0, 1'b1, 64'h0000_0000_CCCC_DDDD};

        for (int i = 0; i < NREG; i++) mregs[i] = '0;
        merrcnt = 0;
        bus.mreq = 0;  bus.mwrite = 0;  bus.maddr = '0;  bus.mwstrb = '0;  bus.mdata = '0;  bus.mmaster = 0;
        bus3.mreq = 0; bus3.mwrite = 0; bus3.maddr = '0; bus3.mwstrb = '0; bus3.mdata = '0; bus3.mmaster = 0;
        hresetn = 1'b0;
        rst3_n  = 1'b0;
        repeat (2) @(posedge hclk);
        #1;
        chk("reset sready", 64'(bus.sready), 64'd0);
        chk("reset sresp",  64'(bus.sresp),  64'd0);
        chk("reset sdata",  bus.sdata,       64'd0);
        chk("reset3 sready", 64'(bus3.sready), 64'd0);
        chk_regs("reset");
        hresetn = 1'b1;
        rst3_n  = 1'b1;
        @(posedge hclk); #1;

        for (int i = 0; i < NV; i++) begin
            xfer(vecs[i].w, vecs[i].a, vecs[i].s, vecs[i].d, vecs[i].m, rd, rs, lat);
            chk($sformatf("vec%0d latency", i), 64'(lat), 64'(WAIT + 1));
            chk($sformatf("vec%0d sresp", i), 64'(rs), 64'(vecs[i].exp_resp));
            if (vecs[i].chk_data) chk($sformatf("vec%0d sdata", i), rd, vecs[i].exp_data);
            model_apply(vecs[i].w, vecs[i].a, vecs[i].s, vecs[i].d, vecs[i].m, er, ed);
            chk_regs($sformatf("vec%0d", i));
        end

        // Outside ACK: sready low, sresp low, sdata holds.
        @(posedge hclk); #1;
        chk("idle sready", 64'(bus.sready), 64'd0);
        chk("idle sdata hold", bus.sdata, 64'h0000_0000_CCCC_DDDD);
        xfer(1'b0, 20, 8'h00, 64'h0, 1'b0, rd, rs, lat);
        model_apply(1'b0, 20, 8'h00, 64'h0, 1'b0, er, ed);
        chk("oob read sresp", 64'(rs), 64'(er));
        @(posedge hclk); #1;
        chk("idle sresp low", 64'(bus.sresp), 64'd0);
        chk("idle sdata after err", bus.sdata, 64'd0);

        // Back-to-back: write reg 2 then read it with mreq held.
        xv = 64'h5A5A_0F0F_C3C3_9696;
        bus.mwrite = 1'b1; bus.maddr = 15'd2; bus.mwstrb = 8'hFF; bus.mdata = xv; bus.mmaster = 1'b0;
        bus.mreq = 1'b1;
        lat = 0;
        do begin @(posedge hclk); #1; lat++; end while (!bus.sready && lat < 20);
        chk("b2b first latency", 64'(lat), 64'(WAIT + 1));
        model_apply(1'b1, 2, 8'hFF, xv, 1'b0, er, ed);
        bus.mwrite = 1'b0;
        @(posedge hclk); #1;
        chk("b2b gap sready", 64'(bus.sready), 64'd0);
        lat2 = 1;
        while (!bus.sready && lat2 < 20) begin @(posedge hclk); #1; lat2++; end
        chk("b2b spacing", 64'(lat2), 64'(WAIT + 1));
        chk("b2b read data", bus.sdata, xv);
        chk("b2b read sresp", 64'(bus.sresp), 64'd0);
        bus.mreq = 1'b0;
        @(posedge hclk); #1;
        chk("b2b pulse ended", 64'(bus.sready), 64'd0);

        // Register NREG-1: error counter or protected RW depending on build.
        xfer(1'b0, NREG - 1, 8'h00, 64'h0, 1'b0, rd, rs, lat);
        model_apply(1'b0, NREG - 1, 8'h00, 64'h0, 1'b0, er, ed);
        chk("last reg read", rd, ed);
        xfer(1'b1, NREG - 1, 8'hFF, 64'hFEED_FACE_CAFE_F00D, 1'b0, rd, rs, lat);
        model_apply(1'b1, NREG - 1, 8'hFF, 64'hFEED_FACE_CAFE_F00D, 1'b0, er, ed);
        chk("last reg write sresp", 64'(rs), 64'(er));
        chk_regs("last reg");

        for (int i = 0; i < 250; i++) begin
            w = 1'($urandom_range(0, 1));
            m = 1'($urandom_range(0, 1));
            a = ($urandom_range(0, 9) == 0) ? int'($urandom_range(16, 32767)) : int'($urandom_range(0, 15));
            s = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            d = {32'($urandom), 32'($urandom)};
            xfer(w, a, s, d, m, rd, rs, lat);
            model_apply(w, a, s, d, m, er, ed);
            chk($sformatf("rnd%0d latency", i), 64'(lat), 64'(WAIT + 1));
            chk($sformatf("rnd%0d sresp", i), 64'(rs), 64'(er));
            if (er || !w) chk($sformatf("rnd%0d sdata", i), rd, ed);
            if (i % 10 == 0) chk_regs($sformatf("rnd%0d", i));
        end
        chk_regs("rnd end");

        // WAIT=3 instance: reset while counting down must cancel the write.
        bus3.mwrite = 1'b1; bus3.maddr = 15'd5; bus3.mwstrb = 8'hFF;
        bus3.mdata = 64'h7777_6666_5555_4444; bus3.mmaster = 1'b0; bus3.mreq = 1'b1;
        repeat (2) begin @(posedge hclk); #1; end
        chk("w3 in wait sready", 64'(bus3.sready), 64'd0);
        rst3_n = 1'b0;
        #1;
        chk("w3 reset sready", 64'(bus3.sready), 64'd0);
        chk("w3 reset sresp",  64'(bus3.sresp),  64'd0);
        bus3.mreq = 1'b0;
        @(posedge hclk); #1;
        rst3_n = 1'b1;
        repeat (4) begin
            @(posedge hclk); #1;
            chk("w3 no late ack", 64'(bus3.sready), 64'd0);
        end
        chk("w3 reg5 unchanged", reg_q3[5*DW +: DW], 64'd0);

        bus3.mwrite = 1'b0; bus3.maddr = 15'd0; bus3.mreq = 1'b1;
        lat = 0;
        do begin @(posedge hclk); #1; lat++; end while (!bus3.sready && lat < 20);
        bus3.mreq = 1'b0;
        chk("w3 latency", 64'(lat), 64'd4);
        chk("w3 id read", bus3.sdata, ID);
        chk("w3 id sresp", 64'(bus3.sresp), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
